// File: rtl/mash_dac_pkg.sv
// mash_dac_pkg: shared constants, sample type and thermometer helper for the
// mash11 -> DWA unit-element DAC path.
package mash_dac_pkg;

    localparam int          DAC_BW_DFLT = 4;
    localparam int          THERM_MAX   = 256;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form
    localparam logic [15:0] LFSR_TAPS   = 16'h002D;

    typedef logic signed [DAC_BW_DFLT-1:0] mash_sample_t;

    function automatic logic [THERM_MAX-1:0] f_therm(input int unsigned k);
        logic [THERM_MAX-1:0] t;
        for (int unsigned i = 0; i < THERM_MAX; i++) t[i] = (i < k);
        return t;
    endfunction

endpackage

// File: rtl/dwa_therm_rotate.sv
// dwa_therm_rotate: rotates a k-element thermometer word to start at ptr and
// computes the next DWA pointer (single conditional subtract modulo N_ELEM).
module dwa_therm_rotate
    import mash_dac_pkg::*;
#(
    parameter  int DAC_BW = DAC_BW_DFLT,
    localparam int N_ELEM = 2**DAC_BW - 1,
    localparam int PTR_W  = $clog2(N_ELEM)
) (
    input  logic [DAC_BW-1:0] i_k,
    input  logic [PTR_W-1:0]  i_ptr,
    input  logic              i_inc,
    output logic [N_ELEM-1:0] o_word,
    output logic [PTR_W-1:0]  o_next_ptr
);

    logic [N_ELEM-1:0] w_therm;
    logic [PTR_W:0]    w_sh;
    logic [PTR_W:0]    w_sum;

    always_comb begin
        w_therm    = N_ELEM'(f_therm(32'(i_k)));
        w_sh       = (PTR_W+1)'(N_ELEM) - {1'b0, i_ptr};
        o_word     = N_ELEM'({w_therm, w_therm} >> w_sh);
        w_sum      = {1'b0, i_ptr} + (PTR_W+1)'(i_k) + (PTR_W+1)'(i_inc);
        o_next_ptr = PTR_W'((w_sum >= (PTR_W+1)'(N_ELEM)) ? w_sum - (PTR_W+1)'(N_ELEM) : w_sum);
    end

endmodule

// File: rtl/axis_dwa_dem.sv
// axis_dwa_dem: AXI-Stream DWA dynamic element matcher driving unit-element DAC pins.
// Optional pointer dither via DWA_LFSR_EN (16-bit Fibonacci LFSR adds lfsr[0]).
module axis_dwa_dem
    import mash_dac_pkg::*;
#(
    parameter  int DAC_BW = DAC_BW_DFLT,
    localparam int N_ELEM = 2**DAC_BW - 1,
    localparam int PTR_W  = $clog2(N_ELEM)
) (
    input  logic                     aclk,
    input  logic                     arst_n,
    input  logic signed [DAC_BW-1:0] s_axis_data_tdata,
    input  logic                     s_axis_data_tvalid,
    output logic                     s_axis_data_tready,
    output logic [N_ELEM-1:0]        m_axis_data_tdata,
    output logic                     m_axis_data_tvalid,
    input  logic                     m_axis_data_tready
);

    logic [PTR_W-1:0]  r_ptr;
    logic [N_ELEM-1:0] r_data;
    logic              r_valid;
    logic [DAC_BW-1:0] w_k;
    logic              w_in_xfer;
    logic              w_inc;
    logic [N_ELEM-1:0] w_word;
    logic [PTR_W-1:0]  w_next_ptr;

    always_comb begin
        // offset-binary count: adding 2**(DAC_BW-1) just flips the sign bit
        w_k                = {~s_axis_data_tdata[DAC_BW-1], s_axis_data_tdata[DAC_BW-2:0]};
        s_axis_data_tready = arst_n & (~r_valid | m_axis_data_tready);
        w_in_xfer          = s_axis_data_tvalid & s_axis_data_tready;
        m_axis_data_tdata  = r_data;
        m_axis_data_tvalid = r_valid;
    end

`ifdef DWA_LFSR_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n)
            r_lfsr <= LFSR_SEED;
        else if (w_in_xfer)
            r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
    end

    assign w_inc = r_lfsr[0];
`else
    assign w_inc = 1'b0;
`endif

    dwa_therm_rotate #(.DAC_BW(DAC_BW)) u_rot (
        .i_k        (w_k),
        .i_ptr      (r_ptr),
        .i_inc      (w_inc),
        .o_word     (w_word),
        .o_next_ptr (w_next_ptr)
    );

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_ptr   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_ptr   <= w_next_ptr;
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (m_axis_data_tready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_dwa_dem.sv
// tb_axis_dwa_dem: directed self-checking bench for axis_dwa_dem (DAC_BW=4).
module tb_axis_dwa_dem;

    logic              aclk;
    logic              arst_n;
    logic signed [3:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [14:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tready;

    int total = 0;
    int bad   = 0;

    axis_dwa_dem dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [3:0] d, input logic [14:0] e, input string tag);
        @(negedge aclk);
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(posedge aclk);
        #1 s_tvalid = 1'b0;
        chk({tag, "_v"}, 32'(m_tvalid), 32'd1);
        chk(tag, 32'(m_tdata), 32'(e));
    endtask

    initial begin
        arst_n   = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_valid", 32'(m_tvalid), 32'd0);
        chk("rst_data", 32'(m_tdata), 32'd0);
        chk("rst_ready", 32'(s_tready), 32'd0);
        arst_n = 1'b1;
        #1 chk("rel_ready", 32'(s_tready), 32'd1);

`ifdef DWA_LFSR_EN
        begin
            logic [15:0] lf;
            logic [14:0] w;
            int          p;
            int          k;
            logic [3:0]  d;
            lf = 16'hACE1;
            p  = 0;
            for (int n = 0; n < 100; n++) begin
                d = 4'($urandom_range(0, 15));
                k = int'({~d[3], d[2:0]});
                w = '0;
                for (int j = 0; j < k; j++) w[(p + j) % 15] = 1'b1;
                p  = (p + k + int'(lf[0])) % 15;
                lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
                xfer(d, w, "lfsr_word");
                chk("lfsr_ptr", 32'(dut.r_ptr), 32'(p));
            end
        end
`else
        xfer(4'h8, 15'h0000, "k0");
        xfer(4'h7, 15'h7FFF, "k15");
        chk("k15_ptr", 32'(dut.r_ptr), 32'd0);
        @(posedge aclk);
        #1 chk("idle_valid", 32'(m_tvalid), 32'd0);
        chk("idle_hold", 32'(m_tdata), 32'h7FFF);

        xfer(4'hB, 15'h0007, "k3a");
        xfer(4'hB, 15'h0038, "k3b");
        chk("k3_ptr", 32'(dut.r_ptr), 32'd6);
        xfer(4'h8, 15'h0000, "k0_p6");
        chk("k0_ptr", 32'(dut.r_ptr), 32'd6);
        xfer(4'h7, 15'h7FFF, "k15_p6");
        chk("k15_ptr6", 32'(dut.r_ptr), 32'd6);

        xfer(4'hE, 15'h0FC0, "k6");
        chk("k6_ptr", 32'(dut.r_ptr), 32'd12);
        xfer(4'hD, 15'h7003, "wrap");
        chk("wrap_ptr", 32'(dut.r_ptr), 32'd2);

        @(negedge aclk);
        m_tready = 1'b0;
        s_tdata  = 4'h9;
        s_tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            chk("bp_data", 32'(m_tdata), 32'h7003);
            chk("bp_valid", 32'(m_tvalid), 32'd1);
            chk("bp_ready", 32'(s_tready), 32'd0);
            chk("bp_ptr", 32'(dut.r_ptr), 32'd2);
        end
        m_tready = 1'b1;
        @(posedge aclk);
        #1 s_tvalid = 1'b0;
        chk("bp_rel_data", 32'(m_tdata), 32'h0004);
        chk("bp_rel_ptr", 32'(dut.r_ptr), 32'd3);
        @(posedge aclk);
        #1 chk("bp_one_valid", 32'(m_tvalid), 32'd0);
        chk("bp_one_ptr", 32'(dut.r_ptr), 32'd3);

        @(negedge aclk);
        #3 arst_n = 1'b0;
        #1 chk("arst_valid", 32'(m_tvalid), 32'd0);
        chk("arst_data", 32'(m_tdata), 32'd0);
        chk("arst_ready", 32'(s_tready), 32'd0);
        chk("arst_ptr", 32'(dut.r_ptr), 32'd0);
        @(negedge aclk);
        arst_n = 1'b1;

        begin
            logic [14:0] seen;
            logic [14:0] e;
            seen = '0;
            for (int i = 0; i < 15; i++) begin
                e = 15'd1 << i;
                xfer(4'h9, e, "k1_walk");
                seen = seen | m_tdata;
            end
            chk("k1_all", 32'(seen), 32'h7FFF);
            chk("k1_ptr", 32'(dut.r_ptr), 32'd0);
        end

        @(negedge aclk);
        s_tdata  = 4'hB;
        s_tvalid = 1'b1;
        @(posedge aclk);
        #1 chk("b2b_a", 32'(m_tdata), 32'h0007);
        @(posedge aclk);
        #1 s_tvalid = 1'b0;
        chk("b2b_b", 32'(m_tdata), 32'h0038);
        chk("b2b_valid", 32'(m_tvalid), 32'd1);
        chk("b2b_ptr", 32'(dut.r_ptr), 32'd6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
